cdf_store_packer: RTL and testbench
===================================

# cdf_store_packer

Parametrised store stage for the CDF pipeline. It accepts a stream of narrow CDF results, zero-extends each into a fixed-width lane and packs several lanes into one wide memory word. Each word is buffered in a small output FIFO and written at auto-incrementing addresses under a ready/enable handshake. A run is bounded by a programmed result count, a partial last word is flushed with a lane mask, and `done` is pulsed once the final word has been accepted by memory.

## Interface
- `RESULT_W`, 20: result width; must be ≤ `LANE_W`
- `LANE_W`, 32: lane width inside the write word
- `BUS_W`, 128: write-bus width; `LANES = BUS_W/LANE_W` (default 4)
- `ADDR_W`, 16: word-address width
- `CNT_W`, 16: result-count width
- `FIFO_DEPTH`, 4: output word FIFO depth; power of two, ≥ 2
- `clock` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `Begin` in 1: one-cycle run start; honoured only in IDLE
- `BaseAddressIn` in ADDR_W: first word address, latched on `Begin`
- `CountIn` in CNT_W: number of results in the run, latched on `Begin`
- `StartIn` in 1: result valid
- `ResultIn` in RESULT_W: result data
- `InReady` out 1: result accepted when `StartIn & InReady`
- `WriteBus` out BUS_W: packed word; lane i occupies bits [i·LANE_W +: LANE_W]
- `WriteMask` out LANES: per-lane valid bits
- `WriteAddress` out ADDR_W: word address
- `WriteEnable` out 1: write request
- `WriteReady` in 1: memory accepts when `WriteEnable & WriteReady`
- `done` out 1: one-cycle pulse at end of run

## Operation
- States: IDLE, PACK, DRAIN, DONE.
- IDLE. On `Begin`: latch the base address and count; clear the lane index, word index and pack register.
  - If `CountIn == 0`, go to DONE.
  - Otherwise go to PACK.
- PACK.
  - `InReady = !fifo_full`.
  - Each accepted result is zero-extended to `LANE_W` and written into lane `lane_idx`; the matching mask bit is set.
  - The word is pushed into the FIFO on the same edge as the last lane write when either:
    - `lane_idx == LANES-1`, or
    - the accepted result is the final one of the run.
  - A pushed word carries address = base + word_idx. Address arithmetic is modulo 2^ADDR_W, so it wraps silently.
  - After a push, word_idx increments and the pack register and mask clear.
  - After the final result is accepted, go to DRAIN.
- DRAIN.
  - `InReady = 0`.
  - When the FIFO empties (last pop accepted), go to DONE.
- DONE. `done = 1` for exactly one cycle, then go to IDLE.
- Output side, independent of state:
  - `WriteEnable = !fifo_empty`.
  - `WriteBus`, `WriteMask` and `WriteAddress` present the FIFO head.
  - All three are forced to 0 while `WriteEnable = 0`.
  - The head pops on `WriteEnable & WriteReady`.
- The FIFO may push and pop on the same cycle. When it is full, that combination is allowed because `InReady` has already blocked the push.
- `StartIn` with `InReady = 0` is ignored; the producer holds its data.
- `Begin` outside IDLE is ignored.
- Unused lanes of a partial word carry data 0 and mask 0.

## Timing
- Reset values: `InReady` 0, `WriteBus` 0, `WriteMask` 0, `WriteAddress` 0, `WriteEnable` 0, `done` 0. State returns to IDLE and the FIFO is emptied.
- Reset asserted mid-run discards all buffered words. No write is issued after reset until a new `Begin`.
- `Begin` at edge t gives `InReady = 1` at t+1, provided the count is non-zero.
- A word completed at edge t gives `WriteEnable = 1` from t+1. Minimum input-to-write latency is 1 cycle.
- With `WriteReady` tied high, throughput is one result per cycle and one write per `LANES` results.
- Final pop accepted at edge t gives `done = 1` during t+1.
- Zero count: `Begin` at t gives `done = 1` during t+1, with no writes.

## Structure
- Shared package `cdf_pkg`:
  - state enum `cdf_store_state_t` (IDLE, PACK, DRAIN, DONE)
  - default width constants: `CDF_RESULT_W`, `CDF_BUS_W`, `CDF_ADDR_W`
- One sub-module, `cdf_word_fifo`:
  - parametrised width (`BUS_W + LANES + ADDR_W`) and depth
  - push, pop, full, empty, head outputs
  - asynchronous active-low reset
- Top level contains the FSM, lane packer, counters and output zero-gating.

## Test plan
- Full words: defaults, base 0x0010, count 8, results 1..8 back-to-back, `WriteReady = 1` → two writes:
  - 0x0010 with bus {4,3,2,1} in 32-bit lanes, mask 4'b1111
  - 0x0011 with bus {8,7,6,5}, mask 4'b1111
  - `done` pulses one cycle after the second write.
- Partial flush: count 5, results 0xFFFFF, then 2..5 → second write has lane0 = 5, lanes 1–3 = 0, mask 4'b0001. Lane0 of the first write equals 0x000FFFFF (zero-extended).
- Backpressure: count 24, `WriteReady = 0` → `InReady` falls after 16 results (4 words buffered). Release `WriteReady` → six writes in order at consecutive addresses, no data lost.
- Address wrap: base 0xFFFF, count 8 → writes at 0xFFFF then 0x0000.
- Zero count and ignored inputs:
  - count 0 → `done` the cycle after `Begin`, no `WriteEnable`.
  - `Begin` during PACK → no effect.
  - `StartIn` while in IDLE → no effect.
- Reset mid-run: assert `reset_n = 0` with 2 words buffered → all outputs go to 0 immediately. After release, `WriteEnable` stays 0 until a new run completes a word.

Source files
------------

// File: rtl/cdf_pkg.sv
// Shared types and default widths for the CDF pipeline store stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cdf_store_state_t;

  localparam int CDF_RESULT_W = 20;
  localparam int CDF_BUS_W    = 128;
  localparam int CDF_ADDR_W   = 16;

endpackage

// File: rtl/cdf_word_fifo.sv
// Generic synchronous word FIFO holding packed {address, mask, data} words.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; push+pop same cycle allowed.
module cdf_word_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array: data only, no reset needed since occupancy is tracked separately.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cdf_store_packer.sv
// Packs narrow CDF results into wide lane-masked memory words at incrementing addresses.
// Latency: a word completed at edge t is presented with WriteEnable from t+1.
// Backpressure: InReady drops while the word FIFO is full; WriteReady low holds the FIFO head.
module cdf_store_packer
  import cdf_pkg::*;
#(
  parameter int RESULT_W   = CDF_RESULT_W,
  parameter int LANE_W     = 32,
  parameter int BUS_W      = CDF_BUS_W,
  parameter int ADDR_W     = CDF_ADDR_W,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int LANES     = BUS_W / LANE_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                Begin,
  input  logic [ADDR_W-1:0]   BaseAddressIn,
  input  logic [CNT_W-1:0]    CountIn,
  input  logic                StartIn,
  input  logic [RESULT_W-1:0] ResultIn,
  output logic                InReady,
  output logic [BUS_W-1:0]    WriteBus,
  output logic [LANES-1:0]    WriteMask,
  output logic [ADDR_W-1:0]   WriteAddress,
  output logic                WriteEnable,
  input  logic                WriteReady,
  output logic                done
);

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FW     = BUS_W + LANES + ADDR_W;
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  cdf_store_state_t r_state;
  cdf_store_state_t w_state_nxt;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_word_idx;
  logic [CNT_W-1:0]  r_remaining;
  logic [LIDX_W-1:0] r_lane_idx;
  logic [BUS_W-1:0]  r_pack;
  logic [LANES-1:0]  r_mask;

  logic [BUS_W-1:0]  w_pack_nxt;
  logic [LANES-1:0]  w_mask_nxt;
  logic              w_accept;
  logic              w_last;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FW-1:0]     w_head;
  logic [FCW-1:0]    w_fcount;

  assign InReady     = (r_state == PACK) & ~w_full;
  assign w_accept    = StartIn & InReady;
  assign w_last      = (r_remaining == CNT_W'(1));
  assign w_push      = w_accept & ((r_lane_idx == LIDX_W'(LANES - 1)) | w_last);
  assign WriteEnable = ~w_empty;
  assign w_pop       = WriteEnable & WriteReady;

  // Insert the zero-extended result into the current lane of the pack register.
  always_comb begin
    w_pack_nxt = r_pack;
    w_mask_nxt = r_mask;
    for (int i = 0; i < LANES; i++) begin
      if (r_lane_idx == LIDX_W'(i)) begin
        w_pack_nxt[i*LANE_W +: LANE_W] = LANE_W'(ResultIn);
        w_mask_nxt[i]                  = 1'b1;
      end
    end
  end

  // Next-state and done decode; DRAIN ends on the pop that takes the last buffered word.
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      IDLE:    if (Begin) w_state_nxt = (CountIn == '0) ? DONE : PACK;
      PACK:    if (w_accept && w_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && (w_fcount == FCW'(1))) w_state_nxt = DONE;
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Run bookkeeping and lane packer; a push clears the pack register for the next word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_base      <= '0;
      r_word_idx  <= '0;
      r_remaining <= '0;
      r_lane_idx  <= '0;
      r_pack      <= '0;
      r_mask      <= '0;
    end else if ((r_state == IDLE) && Begin) begin
      r_base      <= BaseAddressIn;
      r_remaining <= CountIn;
      r_word_idx  <= '0;
      r_lane_idx  <= '0;
      r_pack      <= '0;
      r_mask      <= '0;
    end else if (w_accept) begin
      r_remaining <= r_remaining - CNT_W'(1);
      if (w_push) begin
        r_word_idx <= r_word_idx + ADDR_W'(1);
        r_lane_idx <= '0;
        r_pack     <= '0;
        r_mask     <= '0;
      end else begin
        r_lane_idx <= r_lane_idx + LIDX_W'(1);
        r_pack     <= w_pack_nxt;
        r_mask     <= w_mask_nxt;
      end
    end
  end

  cdf_word_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (w_push),
    .push_dat ({r_base + r_word_idx, w_mask_nxt, w_pack_nxt}),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head),
    .count    (w_fcount)
  );

  assign WriteBus     = WriteEnable ? w_head[BUS_W-1:0]              : '0;
  assign WriteMask    = WriteEnable ? w_head[BUS_W +: LANES]         : '0;
  assign WriteAddress = WriteEnable ? w_head[BUS_W+LANES +: ADDR_W] : '0;

endmodule

// File: tb/tb_cdf_store_packer.sv
module tb_cdf_store_packer;

  localparam int L = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         Begin = 1'b0;
  logic [15:0]  BaseAddressIn = '0;
  logic [15:0]  CountIn = '0;
  logic         StartIn = 1'b0;
  logic [19:0]  ResultIn = '0;
  logic         InReady;
  logic [127:0] WriteBus;
  logic [3:0]   WriteMask;
  logic [15:0]  WriteAddress;
  logic         WriteEnable;
  logic         WriteReady = 1'b0;
  logic         done;

  cdf_store_packer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .Begin         (Begin),
    .BaseAddressIn (BaseAddressIn),
    .CountIn       (CountIn),
    .StartIn       (StartIn),
    .ResultIn      (ResultIn),
    .InReady       (InReady),
    .WriteBus      (WriteBus),
    .WriteMask     (WriteMask),
    .WriteAddress  (WriteAddress),
    .WriteEnable   (WriteEnable),
    .WriteReady    (WriteReady),
    .done          (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]  a;
    logic [3:0]   m;
    logic [127:0] d;
  } wr_t;

  wr_t         got[$];
  wr_t         expq[$];
  logic [19:0] res[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_wr_edge = -1;

  always @(posedge clock) cyc = cyc + 1;

  // Observe handshakes half a cycle before the edge that commits them.
  always @(negedge clock) begin
    if (reset_n && WriteEnable && WriteReady) begin
      wr_t e;
      e.a = WriteAddress;
      e.m = WriteMask;
      e.d = WriteBus;
      got.push_back(e);
      last_wr_edge = cyc + 1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: word w holds results w*L .. w*L+L-1 in ascending lanes, at base+w.
  task automatic build_expected(input logic [15:0] base, input int cnt);
    expq.delete();
    for (int w = 0; w * L < cnt; w++) begin
      wr_t e;
      e.a = base + 16'(w);
      e.m = '0;
      e.d = '0;
      for (int j = 0; j < L; j++) begin
        if (w * L + j < cnt) begin
          e.d[j*32 +: 32] = {12'h000, res[w*L + j]};
          e.m[j]          = 1'b1;
        end
      end
      expq.push_back(e);
    end
  endtask

  task automatic fill_random(input int cnt);
    res.delete();
    for (int i = 0; i < cnt; i++) res.push_back(20'($urandom));
  endtask

  task automatic run(input logic [15:0] base, input int cnt, input bit gaps,
                     input bit wr_rand, input int hold, input bit stray);
    int idx;
    int n;
    int begin_edge;
    bit acc;
    build_expected(base, cnt);
    got.delete();

    StartIn    = 1'b1;
    ResultIn   = 20'h12345;
    WriteReady = 1'b1;
    tick;
    check("idle_inready", InReady, 0);
    check("idle_we", WriteEnable, 0);
    StartIn  = 1'b0;
    done_cnt = 0;

    Begin         = 1'b1;
    BaseAddressIn = base;
    CountIn       = 16'(cnt);
    begin_edge    = cyc + 1;
    tick;
    Begin         = 1'b0;
    BaseAddressIn = 16'($urandom);
    CountIn       = 16'($urandom);
    if (cnt > 0) check("inready_after_begin", InReady, 1);

    idx = 0;
    n   = 0;
    while (done_cnt == 0 && n < 3000) begin
      if (n < hold)     WriteReady = 1'b0;
      else if (wr_rand) WriteReady = 1'($urandom_range(0, 1));
      else              WriteReady = 1'b1;
      if (idx < cnt && (!gaps || $urandom_range(0, 3) != 0)) begin
        StartIn  = 1'b1;
        ResultIn = res[idx];
      end else begin
        StartIn  = 1'b0;
        ResultIn = 20'($urandom);
      end
      Begin = stray && (n == 2);
      if (!WriteEnable) check("zero_gate", {WriteBus, WriteMask, WriteAddress}, 0);
      acc = StartIn && InReady;
      tick;
      if (acc) idx++;
      n++;
      if (hold > 0 && n == hold) begin
        check("bp_accepted", idx, 16);
        check("bp_inready", InReady, 0);
      end
    end
    Begin      = 1'b0;
    StartIn    = 1'b0;
    WriteReady = 1'b1;
    check("run_done", done_cnt, 1);
    check("all_accepted", idx, cnt);
    tick;
    tick;
    check("done_once", done_cnt, 1);
    check("done_low", done, 0);
    check("nwrites", got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      check($sformatf("addr[%0d]", i), got[i].a, expq[i].a);
      check($sformatf("mask[%0d]", i), got[i].m, expq[i].m);
      check($sformatf("data[%0d]", i), got[i].d, expq[i].d);
    end
    if (cnt > 0) check("done_after_last_write", done_cyc, last_wr_edge);
    else         check("zero_count_done", done_cyc, begin_edge);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_inready", InReady, 0);
    check("rst_we", WriteEnable, 0);
    check("rst_outs", {WriteBus, WriteMask, WriteAddress}, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    tick;

    // Full words, back-to-back, with a stray Begin mid-run.
    res = '{20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8};
    run(16'h0010, 8, 1'b0, 1'b0, 0, 1'b1);

    // Partial flush with a full-width first result.
    res = '{20'hFFFFF, 20'd2, 20'd3, 20'd4, 20'd5};
    run(16'h0020, 5, 1'b0, 1'b0, 0, 1'b0);

    // Backpressure: memory stalled until the FIFO fills.
    fill_random(24);
    run(16'h0040, 24, 1'b0, 1'b0, 30, 1'b0);

    // Address wrap.
    fill_random(8);
    run(16'hFFFF, 8, 1'b0, 1'b0, 0, 1'b0);

    // Zero-length run.
    res.delete();
    run(16'h1234, 0, 1'b0, 1'b0, 0, 1'b0);

    // Reset with two words buffered.
    got.delete();
    WriteReady    = 1'b0;
    Begin         = 1'b1;
    BaseAddressIn = 16'h0100;
    CountIn       = 16'd16;
    tick;
    Begin   = 1'b0;
    StartIn = 1'b1;
    repeat (10) begin
      ResultIn = 20'($urandom);
      tick;
    end
    StartIn = 1'b0;
    check("pre_reset_we", WriteEnable, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", WriteEnable, 0);
    check("mid_rst_inready", InReady, 0);
    check("mid_rst_outs", {WriteBus, WriteMask, WriteAddress}, 0);
    check("mid_rst_done", done, 0);
    tick;
    tick;
    reset_n    = 1'b1;
    WriteReady = 1'b1;
    repeat (5) tick;
    check("post_rst_we", WriteEnable, 0);
    check("post_rst_writes", got.size(), 0);

    // Randomized runs with input gaps and random write stalls.
    for (int r = 0; r < 6; r++) begin
      int c;
      c = int'($urandom_range(1, 20));
      fill_random(c);
      run(16'($urandom), c, 1'b1, 1'b1, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
